bus_bridge: RTL and testbench

Memory-mapped responder on the CPU data bus of the on-board single-cycle miniRV system. Decodes every data access, routes it to the external DRAM or to on-chip peripheral registers (7-segment display, LEDs, switches, buttons, free-running timer), and returns read data combinationally within the same cycle, as the single-cycle core requires. Owns the 7-segment scan sequencer, input synchronisers and timer counter.

---
 rtl/bridge_pkg.sv | 39 +++
 rtl/seg7_scan.sv | 42 ++++
 rtl/bus_bridge.sv | 120 ++++++++++++
 tb/tb_bus_bridge.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared constants and the 7-segment glyph decoder for the miniRV bus bridge.
package bridge_pkg;

    localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

    localparam logic [11:0] OFF_DIG   = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_BTN   = 12'h078;

    localparam int unsigned SCAN_DIV_DEF  = 25000;
    localparam int unsigned TIMER_DIV_DEF = 25000;

    // Active-low {a,b,c,d,e,f,g,dp}; dp is always off.
    function automatic logic [7:0] seg7_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'h03;
            4'h1: seg = 8'h9F;
            4'h2: seg = 8'h25;
            4'h3: seg = 8'h0D;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h49;
            4'h6: seg = 8'h41;
            4'h7: seg = 8'h1F;
            4'h8: seg = 8'h01;
            4'h9: seg = 8'h09;
            4'hA: seg = 8'h11;
            4'hB: seg = 8'hC1;
            4'hC: seg = 8'h63;
            4'hD: seg = 8'h85;
            4'hE: seg = 8'h61;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit 7-segment driver: one digit lit per SCAN_DIV cycles.
module seg7_scan
    import bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] dig_val,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Decoded straight from the DIG register so a write shows on the next cycle.
    assign dig_en  = ~(8'b1 << idx_q);
    assign dig_seg = seg7_decode(dig_val[{idx_q, 2'b00} +: 4]);

endmodule

// File: rtl/bus_bridge.sv
// Data-bus responder: routes CPU accesses to DRAM or on-chip peripherals,
// and owns the timer, LED/DIG registers and input synchronisers.
module bus_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF,
    parameter int unsigned TIMER_DIV = TIMER_DIV_DEF
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dig_seg
);

    localparam int unsigned PRE_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    logic [31:0]      dig_q, dig_d;
    logic [23:0]      led_q, led_d;
    logic [31:0]      timer_q, timer_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [23:0]      sw_s1_q, sw_s2_q;
    logic [4:0]       btn_s1_q, btn_s2_q;

    logic        periph_sel;
    logic        periph_wr;
    logic [11:0] offset;
    logic [31:0] periph_rdata;

    assign periph_sel = (Bus_addr[31:12] == PERIPH_BASE);
    assign offset     = Bus_addr[11:0];
    assign periph_wr  = Bus_wen & periph_sel;

    assign dram_addr  = Bus_addr[15:2];
    assign dram_wen   = Bus_wen & ~periph_sel;
    assign dram_wdata = Bus_wdata;

    // Single-cycle read mux: returns pre-write register values.
    always_comb begin
        periph_rdata = 32'h0;
        case (offset)
            OFF_DIG:   periph_rdata = dig_q;
            OFF_TIMER: periph_rdata = timer_q;
            OFF_LED:   periph_rdata = {8'h0, led_q};
            OFF_SW:    periph_rdata = {8'h0, sw_s2_q};
            OFF_BTN:   periph_rdata = {27'h0, btn_s2_q};
            default:   periph_rdata = 32'h0;
        endcase
    end

    assign Bus_rdata = periph_sel ? periph_rdata : dram_rdata;

    // A TIMER write overrides any increment due on the same edge.
    always_comb begin
        dig_d   = dig_q;
        led_d   = led_q;
        timer_d = timer_q;
        pre_d   = pre_q + PRE_W'(1);
        if (pre_q == PRE_W'(TIMER_DIV - 1)) begin
            pre_d   = '0;
            timer_d = timer_q + 32'd1;
        end
        if (periph_wr) begin
            case (offset)
                OFF_DIG: dig_d = Bus_wdata;
                OFF_LED: led_d = Bus_wdata[23:0];
                OFF_TIMER: begin
                    timer_d = Bus_wdata;
                    pre_d   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst) begin
            dig_q    <= '0;
            led_q    <= '0;
            timer_q  <= '0;
            pre_q    <= '0;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            dig_q    <= dig_d;
            led_q    <= led_d;
            timer_q  <= timer_d;
            pre_q    <= pre_d;
            sw_s1_q  <= sw;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
        end
    end

    assign led = led_q;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .dig_val (dig_q),
        .dig_en  (dig_en),
        .dig_seg (dig_seg)
    );

endmodule

// File: tb/tb_bus_bridge.sv
// Scoreboard bench for bus_bridge: a driver pushes expected bus/display state
// from a cycle-count reference model; a negedge monitor pops and compares.
module tb_bus_bridge;

    localparam int unsigned SD = 4;
    localparam int unsigned TD = 3;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  button;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dig_seg;

    always #5 cpu_clk = ~cpu_clk;

    bus_bridge #(.SCAN_DIV(SD), .TIMER_DIV(TD)) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_wen    (Bus_wen),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .button     (button),
        .led        (led),
        .dig_en     (dig_en),
        .dig_seg    (dig_seg)
    );

    // External DRAM stand-in (low 8 word-address bits are enough here)
    logic [31:0] dram_mem [256] = '{default: 32'h0};
    always @(posedge cpu_clk) if (dram_wen) dram_mem[dram_addr[7:0]] <= dram_wdata;
    assign dram_rdata = dram_mem[dram_addr[7:0]];

    typedef struct {
        logic [31:0] rdata;
        logic        dwen;
        logic [13:0] daddr;
        logic [31:0] dwdata;
        logic [23:0] led;
        logic [7:0]  en;
        logic [7:0]  seg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    logic [7:0]  seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Reference model: registers plus cycle counts since reset / timer load
    logic [31:0] m_dig, m_base;
    logic [23:0] m_led, m_sw1, m_sw2;
    logic [4:0]  m_btn1, m_btn2;
    int          m_tcnt, m_scan;
    logic [31:0] ref_mem [256] = '{default: 32'h0};

    function automatic logic [31:0] m_timer();
        return m_base + 32'(m_tcnt / TD);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:12] != 20'hFFFFF) return ref_mem[a[9:2]];
        case (a[11:0])
            12'h000: return m_dig;
            12'h020: return m_timer();
            12'h060: return {8'h0, m_led};
            12'h070: return {8'h0, m_sw2};
            12'h078: return {27'h0, m_btn2};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic wen,
                              input logic [31:0] a, input logic [31:0] wd);
        bit per;
        per = (a[31:12] == 20'hFFFFF);
        if (wen && !per) ref_mem[a[9:2]] = wd;
        if (!rst) begin
            m_dig = 0; m_led = 0; m_base = 0; m_tcnt = 0; m_scan = 0;
            m_sw1 = 0; m_sw2 = 0; m_btn1 = 0; m_btn2 = 0;
        end else begin
            m_sw2 = m_sw1; m_sw1 = sw;
            m_btn2 = m_btn1; m_btn1 = button;
            m_scan++;
            if (wen && per && a[11:0] == 12'h020) begin
                m_base = wd; m_tcnt = 0;
            end else begin
                m_tcnt++;
            end
            if (wen && per && a[11:0] == 12'h000) m_dig = wd;
            if (wen && per && a[11:0] == 12'h060) m_led = wd[23:0];
        end
    endtask

    task automatic cyc(input logic rst, input logic wen,
                       input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   idx;
        logic [31:0] sh;
        cpu_rst = rst; Bus_wen = wen; Bus_addr = a; Bus_wdata = wd;
        if (chk_en) begin
            idx      = (m_scan / SD) % 8;
            sh       = m_dig >> (idx * 4);
            e.rdata  = m_read(a);
            e.dwen   = wen & (a[31:12] != 20'hFFFFF);
            e.daddr  = a[15:2];
            e.dwdata = wd;
            e.led    = m_led;
            e.en     = ~(8'b1 << idx);
            e.seg    = seg_tab[sh[3:0]];
            q.push_back(e);
        end
        @(posedge cpu_clk);
        model_edge(rst, wen, a, wd);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge cpu_clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rdata", Bus_rdata, e.rdata);
            chk("dram_wen", 32'(dram_wen), 32'(e.dwen));
            chk("dram_addr", 32'(dram_addr), 32'(e.daddr));
            chk("dram_wdata", dram_wdata, e.dwdata);
            chk("led", 32'(led), 32'(e.led));
            chk("dig_en", 32'(dig_en), 32'(e.en));
            chk("dig_seg", 32'(dig_seg), 32'(e.seg));
        end
    end

    initial begin
        logic [31:0] r, a;
        logic [11:0] off;
        cpu_rst = 1'b0; Bus_wen = 1'b0; Bus_addr = 32'h0; Bus_wdata = 32'h0;
        sw = 24'h0; button = 5'h0;

        // Reset held two cycles; state is known after the first edge
        cyc(1'b0, 1'b0, 32'hFFFFF020, 32'h0);
        chk_en = 1'b1;
        cyc(1'b0, 1'b0, 32'hFFFFF020, 32'h0);
        repeat (2) cyc(1'b1, 1'b0, 32'hFFFFF020, 32'h0);

        // LED write / readback
        cyc(1'b1, 1'b1, 32'hFFFFF060, 32'h00ABCDEF);
        cyc(1'b1, 1'b0, 32'hFFFFF060, 32'h0);

        // Display scan across all digits and a wrap
        cyc(1'b1, 1'b1, 32'hFFFFF000, 32'h12345678);
        repeat (40) cyc(1'b1, 1'b0, 32'hFFFFF000, 32'h0);

        // Timer from reset, wrap, and write on a terminal-count edge
        cyc(1'b0, 1'b0, 32'hFFFFF020, 32'h0);
        repeat (10) cyc(1'b1, 1'b0, 32'hFFFFF020, 32'h0);
        cyc(1'b1, 1'b1, 32'hFFFFF020, 32'hFFFFFFFF);
        repeat (5) cyc(1'b1, 1'b0, 32'hFFFFF020, 32'h0);
        cyc(1'b1, 1'b1, 32'hFFFFF020, 32'h00000055);
        repeat (4) cyc(1'b1, 1'b0, 32'hFFFFF020, 32'h0);

        // Switch synchroniser latency and RO write
        sw = 24'h5A5A5A; button = 5'h15;
        repeat (3) cyc(1'b1, 1'b0, 32'hFFFFF070, 32'h0);
        cyc(1'b1, 1'b1, 32'hFFFFF070, 32'hFFFFFFFF);
        cyc(1'b1, 1'b0, 32'hFFFFF070, 32'h0);
        cyc(1'b1, 1'b0, 32'hFFFFF078, 32'h0);

        // DRAM write/read and unmapped peripheral offset
        cyc(1'b1, 1'b1, 32'h00000104, 32'hDEADBEEF);
        cyc(1'b1, 1'b0, 32'h00000104, 32'h0);
        cyc(1'b1, 1'b1, 32'hFFFFF100, 32'h13572468);
        cyc(1'b1, 1'b0, 32'hFFFFF100, 32'h0);

        // Randomised traffic with occasional resets and input changes
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 7) == 0) sw = 24'($urandom());
            if ($urandom_range(0, 7) == 0) button = 5'($urandom());
            r = $urandom();
            case ($urandom_range(0, 9))
                0: off = 12'h000;
                1: off = 12'h020;
                2: off = 12'h060;
                3: off = 12'h070;
                4: off = 12'h078;
                5: off = {r[11:2], 2'b00};
                default: off = 12'hFFF;
            endcase
            if (off == 12'hFFF) a = {r[31:16], 6'h0, r[9:2], 2'b00};
            else                a = {20'hFFFFF, off};
            cyc(($urandom_range(0, 60) != 0), ($urandom_range(0, 2) == 0), a, $urandom());
        end

        @(negedge cpu_clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
